// File: rtl/spi_regs.sv
// -----------------------------------------------------------------------------
// spi_regs -- memory-mapped SPI master (8-bit, mode 0, MSB first).
//
// Sits on the CPU data bus beside the UART register block and uses the same
// chip-select / register-port handshake. Software owns the SPI chip select
// and the SCK divider; a write to DATA while idle launches one byte transfer.
//
// Register map (i_addr):
//   0 DATA   W: [7:0] tx byte (starts a transfer)   R: {24'd0, rxbyte}
//   1 STATUS R: {29'd0, ovr, done, busy}             W: W1C bit1=done, bit2=ovr
//   2 CTRL   R/W: [7:0] clkdiv, [8] cs_n
//   3 reserved, reads 0, writes ignored
//
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_wr/i_rd   write / read strobes, qualified by i_cs
//   i_cs        block selected
//   i_addr      word register index (CPU address bits [3:2])
//   i_data_in   write data
//   o_data_out  read data, combinational from i_addr (ignores i_cs)
//   o_sck       SPI clock, idles low
//   o_mosi      SPI data out
//   i_miso      SPI data in, synchronous to i_clk
//   o_cs_n      SPI chip select, straight from CTRL[8]
//   o_irq       level interrupt, equals STATUS.done
// -----------------------------------------------------------------------------
module spi_regs #(
    parameter logic [7:0] DIV_RESET = 8'd3
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr,
    input  logic        i_rd,
    input  logic        i_cs,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_data_in,
    output logic [31:0] o_data_out,
    output logic        o_sck,
    output logic        o_mosi,
    input  logic        i_miso,
    output logic        o_cs_n,
    output logic        o_irq
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        busy;

    logic [7:0]  clkdiv_q,  clkdiv_d;
    logic        cs_n_q,    cs_n_d;
    logic        done_q,    done_d;
    logic        ovr_q,     ovr_d;
    logic [7:0]  rxbyte_q,  rxbyte_d;
    logic [7:0]  shifter_q, shifter_d;
    logic [7:0]  halfcnt_q, halfcnt_d;
    logic [3:0]  edgecnt_q, edgecnt_d;
    logic        sck_q,     sck_d;
    logic        mosi_q,    mosi_d;

    // Bus decode
    logic wr_en, rd_en;
    logic data_wr, status_wr, ctrl_wr, data_rd;

    assign wr_en     = i_cs & i_wr;
    assign rd_en     = i_cs & i_rd;
    assign data_wr   = wr_en && (i_addr == 2'd0);
    assign status_wr = wr_en && (i_addr == 2'd1);
    assign ctrl_wr   = wr_en && (i_addr == 2'd2);
    assign data_rd   = rd_en && (i_addr == 2'd0);

    // Only the low byte and cs_n bit of the write bus are ever stored.
    logic unused_wdata;
    assign unused_wdata = ^i_data_in[31:9];

    // Transfer events
    logic start, ovr_set, tick, sck_rise, last_edge;

    assign start    = data_wr && (state_q == ST_IDLE);
    // A DATA write in the completion cycle still sees XFER and is dropped.
    assign ovr_set  = data_wr && (state_q == ST_XFER);
    // >= rather than == so a clkdiv lowered mid-transfer cannot strand halfcnt.
    assign tick     = (state_q == ST_XFER) && (halfcnt_q >= clkdiv_q);
    assign sck_rise = tick && !sck_q;
    // The 16th SCK edge is always a falling one (edges counted 0..15).
    assign last_edge = tick && (edgecnt_q == 4'd15);

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_XFER;
            ST_XFER: if (last_edge) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == ST_XFER);
    end

    // Datapath next state
    always_comb begin
        clkdiv_d  = clkdiv_q;
        cs_n_d    = cs_n_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        rxbyte_d  = rxbyte_q;
        shifter_d = shifter_q;
        halfcnt_d = halfcnt_q;
        edgecnt_d = edgecnt_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;

        if (ctrl_wr) begin
            clkdiv_d = i_data_in[7:0];
            cs_n_d   = i_data_in[8];
        end

        if (start) begin
            shifter_d = i_data_in[7:0];
            mosi_d    = i_data_in[7];
            sck_d     = 1'b0;
            halfcnt_d = 8'd0;
            edgecnt_d = 4'd0;
        end else if (state_q == ST_XFER) begin
            if (tick) begin
                halfcnt_d = 8'd0;
                sck_d     = ~sck_q;
                edgecnt_d = edgecnt_q + 4'd1;
                if (sck_rise) begin
                    shifter_d = {shifter_q[6:0], i_miso};
                end else if (!last_edge) begin
                    // After the preceding shift, bit 7 is the next bit to send.
                    mosi_d = shifter_q[7];
                end
            end else begin
                halfcnt_d = halfcnt_q + 8'd1;
            end
        end

        if (last_edge) begin
            rxbyte_d = shifter_q;
        end

        // Completion beats a same-cycle clear by W1C or DATA read.
        if (last_edge) begin
            done_d = 1'b1;
        end else if ((status_wr && i_data_in[1]) || data_rd) begin
            done_d = 1'b0;
        end

        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (status_wr && i_data_in[2]) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clkdiv_q  <= DIV_RESET;
            cs_n_q    <= 1'b1;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            rxbyte_q  <= 8'd0;
            shifter_q <= 8'd0;
            halfcnt_q <= 8'd0;
            edgecnt_q <= 4'd0;
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            clkdiv_q  <= clkdiv_d;
            cs_n_q    <= cs_n_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            rxbyte_q  <= rxbyte_d;
            shifter_q <= shifter_d;
            halfcnt_q <= halfcnt_d;
            edgecnt_q <= edgecnt_d;
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
        end
    end

    // Read mux
    always_comb begin
        o_data_out = 32'd0;
        case (i_addr)
            2'd0:    o_data_out = {24'd0, rxbyte_q};
            2'd1:    o_data_out = {29'd0, ovr_q, done_q, busy};
            2'd2:    o_data_out = {23'd0, cs_n_q, clkdiv_q};
            default: o_data_out = 32'd0;
        endcase
    end

    assign o_sck  = sck_q;
    assign o_mosi = mosi_q;
    assign o_cs_n = cs_n_q;
    assign o_irq  = done_q;

endmodule

// File: doc/spi_regs.md
Name: spi_regs

Overview:
- Memory-mapped SPI master peripheral on the CPU data bus, sitting beside the UART register block.
- Uses the same chip-select/register-port handshake as the UART block, so the top-level bus mux consumes o_data_out when its address window is selected.
- Transfers are 8-bit, SPI mode 0, MSB first. Software controls chip select and the SCK divider.
- Intended window: 0x00008020–0x0000802F, decoded outside this block into i_cs.

Parameters:
- DIV_RESET, 8'd3, reset value of CTRL.clkdiv. SCK half-period is clkdiv+1 clocks.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge (the top level feeds an inverted CPU clock).
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_wr  in  1  write strobe; effective only with i_cs.
- i_rd  in  1  read strobe; effective only with i_cs; used for read side effects.
- i_cs  in  1  block selected.
- i_addr  in  2  word register index (CPU address bits [3:2]).
- i_data_in  in  32  write data.
- o_data_out  out  32  read data; combinational from i_addr, independent of i_cs.
- o_sck  out  1  SPI clock; idles low.
- o_mosi  out  1  SPI data out.
- i_miso  in  1  SPI data in; treated as synchronous to i_clk.
- o_cs_n  out  1  SPI chip select; driven directly from CTRL bit 8.
- o_irq  out  1  level, equals STATUS.done.

Behaviour:
- Reset values (asynchronous, immediate):
  - o_sck=0, o_mosi=0, o_cs_n=1, o_irq=0.
  - busy=0, done=0, ovr=0, rxbyte=0.
  - clkdiv=DIV_RESET, FSM=IDLE.
- Register map (i_addr):
  - 0 DATA. Write: [7:0] is the tx byte. Read: {24'd0, rxbyte}.
  - 1 STATUS. Read: {29'd0, ovr, done, busy}. Write: W1C; bit1 clears done, bit2 clears ovr; bit0 ignored.
  - 2 CTRL. R/W: [7:0] clkdiv, [8] cs_n. Reads {23'd0, cs_n, clkdiv}.
  - 3 reserved. Reads 0; writes ignored.
- Read side effect: i_cs && i_rd && i_addr==0 clears done on that edge.
- Start of transfer:
  - Trigger: i_cs && i_wr && i_addr==0 while FSM=IDLE.
  - Next edge: FSM=XFER, busy=1, shifter=byte, o_mosi=byte[7], o_sck=0, halfcnt=0, edgecnt=0.
- DATA write while FSM=XFER (including the completion cycle): write is dropped and ovr is set to 1. The shifter is untouched.
- XFER timing:
  - halfcnt counts 0..clkdiv. When halfcnt==clkdiv: halfcnt returns to 0, o_sck toggles, edgecnt increments.
  - Rising SCK edge: shifter <= {shifter[6:0], i_miso}.
  - Falling SCK edge: o_mosi <= shifter[7], which now holds the next bit.
  - On the 16th edge (falling): FSM=IDLE, busy=0, rxbyte=shifter, done=1. o_mosi is not updated on this edge.
- Latency: busy high for exactly 16*(clkdiv+1) clocks. done/rxbyte are visible on the edge busy falls.
- clkdiv is sampled live. Software must not change CTRL while busy; doing so gives undefined SCK period but must not hang the FSM. edgecnt still terminates at 16, and halfcnt compares with >= so it never overruns.
- Simultaneous events:
  - done set by completion wins over a W1C clear or a DATA read in the same cycle.
  - ovr set wins over an ovr clear in the same cycle.
- o_cs_n is not gated by the FSM. It is a pure software-controlled level.
- Reset asserted mid-transfer: transfer aborts, all state returns to reset values, and no done is flagged after release.

Test Plan:
- Reset: after release → o_data_out for CTRL=0x00000103, STATUS=0, o_sck=0, o_cs_n=1.
- clkdiv=0, i_miso looped to o_mosi, write DATA=0xA5 → busy for 16 clocks, 8 SCK rising edges at 2-clock period, then DATA reads 0x000000A5 and STATUS=0x2, o_irq=1. A following DATA read clears done.
- clkdiv=3, i_miso tied 1, write 0x3C → busy 64 clocks, MOSI sequence 0,0,1,1,1,1,0,0 sampled at rising edges, rx=0xFF.
- Write DATA=0x11 during a transfer of 0x22 → STATUS.ovr=1, transmitted byte remains 0x22. Write STATUS=0x4 → ovr=0.
- DATA read or STATUS W1C of done in the exact completion cycle → done still reads 1 afterward.
- Assert i_rst_n low at edge 7 of a transfer → o_sck=0 immediately, STATUS=0 after release, and the next transfer of 0x5A completes normally.
